param_pipe_adder: RTL and testbench
===================================

PARAM_PIPE_ADDER -- requirements
Module: param_pipe_adder

Interface
REQ-001 The block SHALL have one clock, Clock; reset is asynchronous and active-high, Reset.
REQ-002 Parameter WIDTH, default 32, SHALL set the operand and sum width in bits.
REQ-003 Parameter SEG, default 8, SHALL set the ripple-segment width per pipeline stage; NSTG = WIDTH/SEG.
REQ-004 Clock  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  asynchronous, active-high clear of all state.
REQ-006 in_valid  input  1  an operand set is presented.
REQ-007 in_ready  output  1  the block accepts the operand set this cycle.
REQ-008 A, B  input  WIDTH  operands.
REQ-009 CI  input  1  carry-in, used when in_sub=0.
REQ-010 in_sub  input  1  1 = compute A - B.
REQ-011 out_valid  output  1  S/CO hold a completed result.
REQ-012 out_ready  input  1  the consumer takes the result this cycle.
REQ-013 S  output  WIDTH  sum or difference.
REQ-014 CO  output  1  carry-out of the MSB (for subtract: 1 = no borrow).

Function
REQ-015 Transfer rule: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-016 Effective operands: in_sub=0 -> A + B + CI; in_sub=1 -> A + ~B + 1, with CI ignored.
REQ-017 Stage k (0..NSTG-1) SHALL add bits [k*SEG+SEG-1 : k*SEG] using the carry registered by stage k-1 (stage 0 uses the effective carry-in); A, B, in_sub and the lower partial sum are forwarded in registers.
REQ-018 Latency: an accepted set SHALL appear with out_valid=1 exactly NSTG cycles after acceptance if no stall occurs; throughput is one result per cycle.
REQ-019 Each stage SHALL carry a valid bit; advance = out_ready || !out_valid; in_ready = advance.
REQ-020 When advance=0, all stage registers and valid bits SHALL hold; S, CO and out_valid SHALL stay stable until consumed.
REQ-021 Bubbles (in_valid=0 while advance=1) SHALL propagate as invalid slots; no result is duplicated or dropped.
REQ-022 Simultaneous output consume and input accept in one cycle SHALL be legal with full pipeline (no bubble inserted).
REQ-023 Arithmetic is modulo 2^WIDTH; overflow wraps and is reported only via CO (and out_ovf when enabled).
REQ-024 WIDTH % SEG != 0 or SEG < 1 SHALL cause an elaboration error.

Reset
REQ-025 On Reset=1, all valid bits, S, CO and all data registers SHALL clear to 0 immediately; out_valid=0, in_ready=1 from the first cycle after release.
REQ-026 Reset during operation SHALL discard all in-flight sets; no partial result is ever emitted afterwards.

Configuration
REQ-027 With macro PADDER_OVF_EN defined, output out_ovf (1 bit) SHALL be added, asserted with the result when a signed two's-complement overflow occurred (operand MSBs equal after effective inversion, result MSB differs); it is reset to 0 and held during stalls.
REQ-028 Without PADDER_OVF_EN, the port and its logic SHALL not exist; all other behaviour is identical.

Structure
REQ-029 Package padder_pkg SHALL hold the default WIDTH/SEG constants and a stage-count function used by the block and the bench.
REQ-030 One sub-module, padder_stage (SEG-bit ripple add plus stage registers with enable), SHALL be instantiated NSTG times via generate.

Verification
REQ-031 WIDTH=32, SEG=8, out_ready=1: A=0xFFFFFFFF, B=0x00000001, CI=0 -> after 4 cycles, S=0x00000000, CO=1.
REQ-032 Back-to-back 10 sets, out_ready=1 -> 10 consecutive out_valid cycles, in order, first one 4 cycles after the first accept.
REQ-033 Subtract: A=5, B=7, in_sub=1, CI=1 -> S=0xFFFFFFFE, CO=0 (CI ignored).
REQ-034 Full pipeline, out_ready=0 for 3 cycles -> in_ready=0, S/CO stable; on release, no loss or duplication.
REQ-035 Reset asserted with 3 sets in flight -> out_valid=0 immediately, none of the 3 is ever output.
REQ-036 PADDER_OVF_EN, A=0x7FFFFFFF, B=1, CI=0 -> S=0x80000000, out_ovf=1, CO=0; repeat with WIDTH=16, SEG=4 (latency 4).

Source files
------------

// File: rtl/param_pipe_adder_pkg.sv
// padder_pkg: default adder geometry and the stage-count helper shared by the block and its bench
package padder_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG = 8;
  function automatic int stage_count(input int width, input int seg);
    return seg > 0 ? width / seg : 1;
  endfunction
endpackage

// File: rtl/param_pipe_adder_if.sv
// param_pipe_adder_if: operand/result handshake bundle; out_ovf exists only when PADDER_OVF_EN is defined
interface param_pipe_adder_if
  import padder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CI;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             CO;
`ifdef PADDER_OVF_EN
  logic             out_ovf;
  modport slave (
    input  in_valid, A, B, CI, in_sub, out_ready,
    output in_ready, out_valid, S, CO, out_ovf
  );
  modport master (
    output in_valid, A, B, CI, in_sub, out_ready,
    input  in_ready, out_valid, S, CO, out_ovf
  );
`else
  modport slave (
    input  in_valid, A, B, CI, in_sub, out_ready,
    output in_ready, out_valid, S, CO
  );
  modport master (
    output in_valid, A, B, CI, in_sub, out_ready,
    input  in_ready, out_valid, S, CO
  );
`endif
endinterface

// File: rtl/param_pipe_adder_stage.sv
// padder_stage: one SEG-bit ripple segment of the pipelined adder with enable-gated stage registers
module padder_stage
  import padder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG,
  parameter int K     = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             en,
  input  logic             v_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] s_in,
  input  logic             sub_in,
  input  logic             c_in,
  output logic             v_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] s_q,
  output logic             sub_q,
  output logic             c_q
);
  localparam int LO = K * SEG;
  logic [SEG:0]     seg_sum;
  logic [WIDTH-1:0] s_next;
  // add this stage's slice (B inverted for subtract) and splice it into the partial sum
  always_comb begin
    seg_sum = {1'b0, a_in[LO+:SEG]} + {1'b0, b_in[LO+:SEG] ^ {SEG{sub_in}}} + {{SEG{1'b0}}, c_in};
    s_next = s_in;
    s_next[LO+:SEG] = seg_sum[SEG-1:0];
  end
  // stage registers advance together and hold while the pipeline is stalled
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      v_q   <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      sub_q <= 1'b0;
      c_q   <= 1'b0;
    end else if (en) begin
      v_q   <= v_in;
      a_q   <= a_in;
      b_q   <= b_in;
      s_q   <= s_next;
      sub_q <= sub_in;
      c_q   <= seg_sum[SEG];
    end
  end
endmodule

// File: rtl/param_pipe_adder.sv
// param_pipe_adder: WIDTH-bit add/subtract pipelined in SEG-bit ripple stages; define PADDER_OVF_EN for out_ovf
module param_pipe_adder
  import padder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input logic               Clock,
  input logic               Reset,
  param_pipe_adder_if.slave bus
);
  localparam int NSTG = stage_count(WIDTH, SEG);
  if (SEG < 1 || (WIDTH % (SEG < 1 ? 1 : SEG)) != 0) begin : g_bad_geometry
    $error("param_pipe_adder: WIDTH must be a positive multiple of SEG");
  end
  logic             advance;
  logic             v_c   [NSTG+1];
  logic [WIDTH-1:0] a_c   [NSTG+1];
  logic [WIDTH-1:0] b_c   [NSTG+1];
  logic [WIDTH-1:0] s_c   [NSTG+1];
  logic             sub_c [NSTG+1];
  logic             c_c   [NSTG+1];
  logic             unused_tail;
  assign advance       = bus.out_ready || !v_c[NSTG];
  assign bus.in_ready  = advance;
  assign bus.out_valid = v_c[NSTG];
  assign bus.S         = s_c[NSTG];
  assign bus.CO        = c_c[NSTG];
  assign v_c[0]        = bus.in_valid;
  assign a_c[0]        = bus.A;
  assign b_c[0]        = bus.B;
  assign s_c[0]        = '0;
  assign sub_c[0]      = bus.in_sub;
  assign c_c[0]        = bus.in_sub | bus.CI;
  genvar k;
  for (k = 0; k < NSTG; k++) begin : g_stg
    padder_stage #(.WIDTH(WIDTH), .SEG(SEG), .K(k)) u_stg (
      .Clock (Clock),
      .Reset (Reset),
      .en    (advance),
      .v_in  (v_c[k]),
      .a_in  (a_c[k]),
      .b_in  (b_c[k]),
      .s_in  (s_c[k]),
      .sub_in(sub_c[k]),
      .c_in  (c_c[k]),
      .v_q   (v_c[k+1]),
      .a_q   (a_c[k+1]),
      .b_q   (b_c[k+1]),
      .s_q   (s_c[k+1]),
      .sub_q (sub_c[k+1]),
      .c_q   (c_c[k+1])
    );
  end
`ifdef PADDER_OVF_EN
  assign bus.out_ovf = (a_c[NSTG][WIDTH-1] == (b_c[NSTG][WIDTH-1] ^ sub_c[NSTG]))
                    && (s_c[NSTG][WIDTH-1] != a_c[NSTG][WIDTH-1]);
`endif
  assign unused_tail = ^{a_c[NSTG], b_c[NSTG], sub_c[NSTG]};
endmodule

// File: tb/tb_param_pipe_adder.sv
// tb_param_pipe_adder: table vectors, scoreboard stream, stall, reset-flush and 16/4 geometry checks
module tb_param_pipe_adder;
  import padder_pkg::*;
  localparam int NS = stage_count(DEF_WIDTH, DEF_SEG);
  typedef struct {
    logic [31:0] a, b;
    logic ci, sub;
    logic [31:0] s;
    logic co, ovf;
  } vec_t;
  typedef struct {
    logic [31:0] s;
    logic co, ovf;
  } exp_t;
  logic Clock = 0;
  logic Reset = 1;
  int tests = 0, fails = 0;
  int cyc = 0, acc_cyc = 0, n_out = 0, first_out = -1, last_out = 0;
  exp_t sb[$];
  vec_t vt[12];
  param_pipe_adder_if #(.WIDTH(32)) bus ();
  param_pipe_adder_if #(.WIDTH(16)) bus2 ();
  param_pipe_adder #(.WIDTH(32), .SEG(8)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  param_pipe_adder #(.WIDTH(16), .SEG(4)) dut2 (.Clock(Clock), .Reset(Reset), .bus(bus2));
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, b, input logic ci, sub);
    logic [32:0] r;
    exp_t e;
    r = sub ? {1'b0, a} + {1'b0, ~b} + 33'd1 : {1'b0, a} + {1'b0, b} + {32'd0, ci};
    e.s = r[31:0];
    e.co = r[32];
    e.ovf = (a[31] == (b[31] ^ sub)) && (r[31] != a[31]);
    return e;
  endfunction

  task automatic send(input logic [31:0] a, b, input logic ci, sub, input exp_t e);
    int g = 0;
    bus.A = a; bus.B = b; bus.CI = ci; bus.in_sub = sub; bus.in_valid = 1;
    while (1) begin
      @(negedge Clock);
      if (bus.in_ready) break;
      g++;
      if (g > 100) break;
    end
    if (g > 100) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready stuck low");
    end else begin
      sb.push_back(e);
      acc_cyc = cyc;
    end
    @(posedge Clock); #1;
    bus.in_valid = 0;
  endtask

  task automatic drain();
    for (int g = 0; g < 60 && sb.size() != 0; g++) begin
      @(posedge Clock); #1;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic t2(input string nm, input logic [15:0] a, b, input logic ci, sub,
                    input logic [15:0] s, input logic co, ovf);
    int n = 1;
    bus2.A = a; bus2.B = b; bus2.CI = ci; bus2.in_sub = sub; bus2.in_valid = 1;
    @(posedge Clock); #1;
    bus2.in_valid = 0;
    while (!bus2.out_valid && n < 20) begin
      @(posedge Clock); #1;
      n++;
    end
    chk({nm, "_lat"}, n, 4);
    chk({nm, "_s"}, bus2.S, s);
    chk({nm, "_co"}, bus2.CO, co);
`ifdef PADDER_OVF_EN
    chk({nm, "_ovf"}, bus2.out_ovf, ovf);
`else
    if (ovf === 1'bx) $display("unreachable");
`endif
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      if (!Reset && bus.out_valid && bus.out_ready) begin
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: S=%0h with empty scoreboard", bus.S);
        end else begin
          e = sb.pop_front();
          chk("sb_s", bus.S, e.s);
          chk("sb_co", bus.CO, e.co);
`ifdef PADDER_OVF_EN
          chk("sb_ovf", bus.out_ovf, e.ovf);
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic rci, rsub;
    vt[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vt[1]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[2]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[3]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
    vt[4]  = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
    vt[5]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vt[6]  = '{32'h00000007, 32'h00000007, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vt[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vt[8]  = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vt[9]  = '{32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0};
    vt[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[11] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    bus.in_valid = 0; bus.A = 0; bus.B = 0; bus.CI = 0; bus.in_sub = 0; bus.out_ready = 1;
    bus2.in_valid = 0; bus2.A = 0; bus2.B = 0; bus2.CI = 0; bus2.in_sub = 0; bus2.out_ready = 1;
    repeat (3) @(posedge Clock);
    #1 Reset = 0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_s", bus.S, 0);
    chk("rst_co", bus.CO, 0);

    begin : latency
      int n = 1;
      send(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, '{32'h0, 1'b1, 1'b0});
      while (!bus.out_valid && n < 20) begin
        @(posedge Clock); #1;
        n++;
      end
      chk("latency", n, NS);
    end
    drain();

    for (int i = 0; i < 12; i++)
      send(vt[i].a, vt[i].b, vt[i].ci, vt[i].sub, '{vt[i].s, vt[i].co, vt[i].ovf});
    drain();

    begin : b2b
      int first_acc = 0;
      n_out = 0; first_out = -1;
      for (int i = 0; i < 10; i++) begin
        ra = $urandom; rb = $urandom; rci = 1'($urandom); rsub = 1'($urandom);
        send(ra, rb, rci, rsub, model(ra, rb, rci, rsub));
        if (i == 0) first_acc = acc_cyc;
      end
      drain();
      chk("b2b_count", n_out, 10);
      chk("b2b_first_lat", first_out - first_acc, NS);
      chk("b2b_contiguous", last_out - first_out, 9);
    end

    n_out = 0;
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rci = 1'($urandom); rsub = 1'($urandom);
      send(ra, rb, rci, rsub, model(ra, rb, rci, rsub));
    end
    ra = $urandom; rb = $urandom; rci = 1'($urandom); rsub = 1'($urandom);
    bus.A = ra; bus.B = rb; bus.CI = rci; bus.in_sub = rsub; bus.in_valid = 1;
    bus.out_ready = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge Clock);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_s", bus.S, sb[0].s);
      chk("stall_co", bus.CO, sb[0].co);
      @(posedge Clock); #1;
    end
    bus.out_ready = 1;
    send(ra, rb, rci, rsub, model(ra, rb, rci, rsub));
    drain();
    chk("stall_no_loss", n_out, 5);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
    end
    @(posedge Clock); #1;
    chk("pre_reset_valid", bus.out_valid, 1);
    #2 Reset = 1;
    #1;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_s", bus.S, 0);
    chk("reset_co", bus.CO, 0);
    sb.delete();
    n_out = 0;
    repeat (2) @(posedge Clock);
    #1 Reset = 0;
    chk("post_reset_in_ready", bus.in_ready, 1);
    repeat (15) @(posedge Clock);
    #1;
    chk("reset_flushed", n_out, 0);
    send(32'h00000003, 32'h00000004, 1'b1, 1'b0, '{32'h00000008, 1'b0, 1'b0});
    drain();

    t2("w16_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    t2("w16_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    t2("w16_sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    chk("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
